// File: rtl/lc3_pkg.sv
// lc3_pkg: shared opcode constants, memory-phase encoding and instruction
// classification helpers for the LC3 pipeline controller.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // Encoding is visible on the mem_state port.
  typedef enum logic [1:0] {
    RD     = 2'd0,
    RD_IND = 2'd1,
    WR     = 2'd2,
    IDLE   = 2'd3
  } mem_state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_ctrl(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// lc3_mem_fsm: data-memory phase sequencer.
//   clk, rst       : clock, synchronous active-high reset
//   start          : execute stage is issuing the instruction this cycle
//   op             : opcode of the instruction in execute
//   complete_data  : data memory finished the current access
//   mem_state      : current phase (0 RD, 1 RD_IND, 2 WR, 3 IDLE)
//   mem_stall      : a memory phase is in progress
//   ld_done        : final read of a load completes this cycle
module lc3_mem_fsm
  import lc3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op,
  input  logic       complete_data,
  output logic [1:0] mem_state,
  output logic       mem_stall,
  output logic       ld_done
);

  mem_state_t state;
  logic       ind_store;  // indirect access finishes with a write (STI)

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ind_store <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ind_store <= (op == OP_STI);
            if (op == OP_LDI || op == OP_STI) state <= RD_IND;
            else if (is_load(op))             state <= RD;
            else if (is_store(op))            state <= WR;
          end
        end
        RD_IND:  if (complete_data) state <= ind_store ? WR : RD;
        RD, WR:  if (complete_data) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_state = state;
  assign mem_stall = (state != IDLE);
  assign ld_done   = (state == RD) && complete_data;

endmodule

// File: rtl/lc3_controller.sv
// lc3_controller: LC3 pipeline sequencer. Produces per-stage enables,
// inserts control-flow and memory bubbles and resolves branches.
//   clk, rst          : clock, synchronous active-high reset
//   Imem_dout         : instruction word seen in the fetch cycle
//   IR_Exec           : instruction in the execute stage
//   NZP               : condition codes from writeback
//   complete_data     : data memory access done
//   enable_updatePC   : PC update strobe
//   enable_fetch      : instruction memory read enable
//   enable_decode     : decode stage enable
//   enable_execute    : execute stage enable
//   enable_writeback  : register file write enable
//   br_taken          : fetch selects taddr instead of npc
//   mem_state         : memory phase (0 RD, 1 RD_IND, 2 WR, 3 IDLE)
module lc3_controller
  import lc3_pkg::*;
#(
  parameter int unsigned RESET_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Imem_dout,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic        complete_data,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state
);

  // v[3]=F, v[2]=D, v[1]=E, v[0]=W
  logic [3:0]  v;
  logic [1:0]  ctrl_cnt;
  logic [15:0] rs_cnt;

  logic [3:0] op_f, op_e;
  logic       mem_stall, ld_done, mem_start;
  logic       fetch_ok, resolve;
  logic       unused_bits;

  assign op_f        = Imem_dout[15:12];
  assign op_e        = IR_Exec[15:12];
  assign unused_bits = ^{Imem_dout[11:0], IR_Exec[8:0]};

  assign resolve   = (ctrl_cnt == 2'd1) && !mem_stall;
  assign fetch_ok  = v[3] && !mem_stall && (ctrl_cnt == 2'd0);

  assign enable_fetch     = fetch_ok;
  assign enable_updatePC  = fetch_ok || resolve;
  assign enable_decode    = v[2] && !mem_stall;
  assign enable_execute   = v[1] && !mem_stall;
  assign enable_writeback = mem_stall ? ld_done : v[0];
  assign br_taken         = resolve &&
                            ((op_e == OP_JMP) ||
                             ((op_e == OP_BR) && |(NZP & IR_Exec[11:9])));

  assign mem_start = enable_execute && (is_load(op_e) || is_store(op_e));

  always_ff @(posedge clk) begin
    if (rst) begin
      v        <= {(RESET_STALL == 0), 3'b000};
      ctrl_cnt <= '0;
      rs_cnt   <= 16'(RESET_STALL);
    end else begin
      if (rs_cnt != '0) rs_cnt <= rs_cnt - 16'd1;
      if (rs_cnt <= 16'd1) v[3] <= 1'b1;
      if (!mem_stall) begin
        v[2] <= fetch_ok;
        v[1] <= v[2];
        // A memory op retires through ld_done, not the normal writeback slot.
        v[0] <= v[1] && !mem_start;
        if (fetch_ok && is_ctrl(op_f)) ctrl_cnt <= 2'd3;
        else if (ctrl_cnt != '0)       ctrl_cnt <= ctrl_cnt - 2'd1;
      end
    end
  end

  lc3_mem_fsm u_mem_fsm (
    .clk           (clk),
    .rst           (rst),
    .start         (mem_start),
    .op            (op_e),
    .complete_data (complete_data),
    .mem_state     (mem_state),
    .mem_stall     (mem_stall),
    .ld_done       (ld_done)
  );

endmodule

// File: tb/tb_lc3_controller.sv
// tb_lc3_controller: directed scenarios followed by random stimulus, all
// checked against a step-indexed behavioural model of the sequencer.
module tb_lc3_controller;

  localparam int unsigned RS = 1;
  localparam logic [15:0] ADD_W = 16'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Imem_dout, IR_Exec;
  logic [2:0]  NZP;
  logic        complete_data;
  logic        enable_updatePC, enable_fetch, enable_decode;
  logic        enable_execute, enable_writeback, br_taken;
  logic [1:0]  mem_state;

  always #5 clk = ~clk;

  lc3_controller #(.RESET_STALL(RS)) dut (
    .clk              (clk),
    .rst              (rst),
    .Imem_dout        (Imem_dout),
    .IR_Exec          (IR_Exec),
    .NZP              (NZP),
    .complete_data    (complete_data),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .mem_state        (mem_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: time counted in unstalled pipeline steps; memory ops as a queue
  // of pending phases (0 read, 1 indirect read, 2 write).
  int m_cyc = 0;
  int m_step = 0;
  int m_ctrl_step = -100;
  bit fetch_at[$];
  bit memx_at[$];
  int phases[$];
  bit e_fetch, e_upd, e_dec, e_exe, e_wb, e_br;
  logic [1:0] e_ms;

  function automatic int opc(input logic [15:0] ir);
    return int'(ir[15:12]);
  endfunction

  function automatic bit op_mem(input logic [15:0] ir);
    int o = opc(ir);
    return o == 2 || o == 6 || o == 10 || o == 3 || o == 7 || o == 11;
  endfunction

  task automatic model_eval();
    if (phases.size() != 0) begin
      {e_fetch, e_upd, e_dec, e_exe, e_br} = '0;
      e_wb = (phases[0] == 0) && complete_data;
      e_ms = 2'(phases[0]);
    end else begin
      int since = m_step - m_ctrl_step;
      e_fetch = (m_cyc >= int'(RS)) && !(since >= 1 && since <= 3);
      e_upd   = e_fetch || since == 3;
      e_br    = since == 3 && (opc(IR_Exec) == 12 ||
                (opc(IR_Exec) == 0 && (NZP & IR_Exec[11:9]) != 3'b000));
      e_dec   = m_step >= 1 && fetch_at[m_step-1];
      e_exe   = m_step >= 2 && fetch_at[m_step-2];
      e_wb    = m_step >= 3 && fetch_at[m_step-3] && !memx_at[m_step-1];
      e_ms    = 2'd3;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_cyc = 0; m_step = 0; m_ctrl_step = -100;
      fetch_at.delete(); memx_at.delete(); phases.delete();
    end else begin
      if (phases.size() != 0) begin
        if (complete_data) void'(phases.pop_front());
      end else begin
        fetch_at.push_back(e_fetch);
        memx_at.push_back(e_exe && op_mem(IR_Exec));
        if (e_fetch && (opc(Imem_dout) == 0 || opc(Imem_dout) == 12)) m_ctrl_step = m_step;
        if (e_exe) begin
          case (opc(IR_Exec))
            2, 6:   phases.push_back(0);
            3, 7:   phases.push_back(2);
            10:     begin phases.push_back(1); phases.push_back(0); end
            11:     begin phases.push_back(1); phases.push_back(2); end
            default: ;
          endcase
        end
        m_step++;
      end
      m_cyc++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    if (!rst) begin
      chk("m_fetch", enable_fetch, e_fetch);
      chk("m_updpc", enable_updatePC, e_upd);
      chk("m_decode", enable_decode, e_dec);
      chk("m_execute", enable_execute, e_exe);
      chk("m_writeback", enable_writeback, e_wb);
      chk("m_br_taken", br_taken, e_br);
      chk("m_mem_state", mem_state, e_ms);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin sample(); advance(); end
  endtask

  task automatic ctrl_case(input string tag, input logic [15:0] instr,
                           input logic [2:0] nzp, input bit taken);
    Imem_dout = instr;
    sample(); chk({tag, "_fetchF"}, enable_fetch, 1); advance();
    Imem_dout = ADD_W;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin IR_Exec = instr; NZP = nzp; end
      sample();
      chk({tag, "_bubble"}, enable_fetch, 0);
      if (i == 3) begin
        chk({tag, "_br"}, br_taken, taken);
        chk({tag, "_upd"}, enable_updatePC, 1);
      end
      advance();
    end
    IR_Exec = ADD_W; NZP = 3'b000;
    sample(); chk({tag, "_resume"}, enable_fetch, 1); advance();
  endtask

  task automatic mem_case(input string tag, input logic [15:0] instr, input int nph,
                          input logic [1:0] p0, input logic [1:0] p1,
                          input int lat, input bit is_ld);
    IR_Exec = instr;
    sample(); chk({tag, "_exe"}, enable_execute, 1); advance();
    IR_Exec = ADD_W;
    for (int p = 0; p < nph; p++) begin
      for (int k = 0; k <= lat; k++) begin
        complete_data = (k == lat);
        sample();
        chk({tag, "_ms"}, mem_state, (p == 0) ? p0 : p1);
        chk({tag, "_fetch"}, enable_fetch, 0);
        chk({tag, "_wb"}, enable_writeback, is_ld && p == nph - 1 && k == lat);
        advance();
      end
    end
    complete_data = 1'b0;
    sample(); chk({tag, "_idle"}, mem_state, 3); advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Imem_dout = ADD_W; IR_Exec = ADD_W; NZP = 3'b000; complete_data = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset release and enable ramp
    sample();
    chk("rst_fetch", enable_fetch, 0); chk("rst_upd", enable_updatePC, 0);
    chk("rst_dec", enable_decode, 0); chk("rst_exe", enable_execute, 0);
    chk("rst_wb", enable_writeback, 0); chk("rst_br", br_taken, 0);
    chk("rst_ms", mem_state, 3);
    advance();
    sample(); chk("c1_fetch", enable_fetch, 1); chk("c1_upd", enable_updatePC, 1);
    chk("c1_dec", enable_decode, 0); advance();
    sample(); chk("c2_dec", enable_decode, 1); chk("c2_exe", enable_execute, 0); advance();
    sample(); chk("c3_exe", enable_execute, 1); chk("c3_wb", enable_writeback, 0); advance();
    sample(); chk("c4_wb", enable_writeback, 1); chk("c4_ms", mem_state, 3); advance();

    // Control flow
    ctrl_case("br_z_taken", 16'h0402, 3'b010, 1);
    ctrl_case("br_z_not", 16'h0402, 3'b100, 0);
    ctrl_case("br_none", 16'h0005, 3'b111, 0);
    ctrl_case("br_all", 16'h0E05, 3'b001, 1);
    ctrl_case("jmp", 16'hC1C0, 3'b000, 1);
    idle(3);

    // Memory sequences
    mem_case("ldi", 16'hA000, 2, 2'd1, 2'd0, 2, 1);
    idle(3);
    mem_case("sti", 16'hB000, 2, 2'd1, 2'd2, 0, 0);
    idle(3);
    mem_case("str", 16'h7000, 1, 2'd2, 2'd2, 1, 0);
    idle(3);

    // BR fetched in the cycle an LD enters execute
    Imem_dout = 16'h0E05; IR_Exec = 16'h2000;
    sample(); chk("sim_fetch", enable_fetch, 1); chk("sim_exe", enable_execute, 1); advance();
    Imem_dout = ADD_W; IR_Exec = ADD_W; complete_data = 1'b1;
    sample(); chk("sim_ms", mem_state, 0); chk("sim_wb", enable_writeback, 1);
    chk("sim_stall_fetch", enable_fetch, 0); advance();
    complete_data = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample(); chk("sim_bubble", enable_fetch, 0); chk("sim_noupd", enable_updatePC, 0); advance();
    end
    sample(); chk("sim_resolve_upd", enable_updatePC, 1); chk("sim_resolve_fetch", enable_fetch, 0);
    chk("sim_br", br_taken, 0); advance();
    sample(); chk("sim_resume", enable_fetch, 1); advance();
    idle(3);

    // Reset during an indirect read
    IR_Exec = 16'hA000;
    sample(); chk("rmid_exe", enable_execute, 1); advance();
    IR_Exec = ADD_W;
    sample(); chk("rmid_ms", mem_state, 1); advance();
    rst = 1'b1; sample(); advance();
    rst = 1'b0;
    sample();
    chk("rmid_ms_after", mem_state, 3); chk("rmid_fetch", enable_fetch, 0);
    chk("rmid_upd", enable_updatePC, 0); chk("rmid_dec", enable_decode, 0);
    chk("rmid_exe_after", enable_execute, 0); chk("rmid_wb", enable_writeback, 0);
    chk("rmid_br", br_taken, 0);
    advance();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      Imem_dout     = 16'($urandom);
      IR_Exec       = 16'($urandom);
      NZP           = 3'($urandom);
      complete_data = ($urandom_range(0, 2) == 0);
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
# lc3_controller

Pipeline sequencer for the LC3 core. Generates per-stage enables for fetch, decode, execute, writeback and memory access. Inserts bubbles for control-flow and memory instructions, resolves branches and drives the PC-select strobe (`br_taken`) into fetch. Sits beside the datapath with no data path of its own: it only observes instruction words, condition codes and memory completion.

## Interface
Parameters:
- `RESET_STALL`, default 1: number of idle cycles after `rst` deasserts before the first fetch.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `Imem_dout` in 16: instruction word returned by instruction memory in the fetch cycle.
- `IR_Exec` in 16: instruction currently held in the execute stage.
- `NZP` in 3: condition codes from writeback.
- `complete_data` in 1: data memory access finished this cycle.
- `enable_updatePC` out 1: PC register update strobe.
- `enable_fetch` out 1: instruction memory read enable.
- `enable_decode` out 1: decode stage enable.
- `enable_execute` out 1: execute stage enable.
- `enable_writeback` out 1: register file write enable.
- `br_taken` out 1: fetch selects `taddr` instead of `npc`.
- `mem_state` out 2: memory phase. 0 = read, 1 = indirect read, 2 = write, 3 = idle.

## Operation
- **Opcodes (bits [15:12]):**
  - ALU: ADD 0001, AND 0101, NOT 1001, LEA 1110.
  - Load: LD 0010, LDR 0110, LDI 1010.
  - Store: ST 0011, STR 0111, STI 1011.
  - Control: BR 0000, JMP 1100.
- **Valid shift chain.** A 4-bit register `v[F,D,E,W]` tracks pipeline occupancy.
  - `v_F` sets when fetch is enabled.
  - Each bit advances only when the downstream stage is enabled.
  - Each stage enable = stage valid AND NOT stall.
- **Control stall.**
  - When `enable_fetch`=1 and `Imem_dout[15:12]` is BR or JMP, load a 2-bit counter with 3.
  - While the counter is nonzero: `enable_fetch`=0 and `enable_updatePC`=0. The counter decrements each non-memory-stalled cycle.
  - In the cycle the counter reaches 1 (resolve cycle), `enable_updatePC`=1.
  - `br_taken` = 1 for JMP, or `|(NZP & IR_Exec[11:9])` for BR.
  - Fetch resumes the next cycle.
  - BR with nzp=000 is never taken. BR with nzp=111 is always taken.
- **Memory FSM** (states IDLE, RD, RD_IND, WR). Entered when `enable_execute`=1 and `IR_Exec` is a load or store.
  - LD/LDR: go to RD.
  - ST/STR: go to WR.
  - LDI and STI: go to RD_IND first. On `complete_data`=1 they move to RD (LDI) or WR (STI).
  - RD or WR plus `complete_data`=1: return to IDLE.
  - Each phase holds for as many cycles as `complete_data` stays low.
  - `mem_state` is the encoding of the current state.
- **Memory stall.** While the FSM is not IDLE:
  - fetch, updatePC, decode and execute enables are 0, and the control counter freezes.
  - `enable_writeback`=1 only in the cycle RD completes (loads).
  - Stores never assert writeback.
- **Simultaneous events.** Memory stall has priority over control stall and fetch. A control instruction fetched in the same cycle a memory op enters execute still loads the counter.
- **Reset.** Synchronous `rst` at any point clears the valid chain, counter and FSM, aborting any in-flight memory phase.

## Timing
- **Reset values:** all enables 0, `br_taken`=0, `mem_state`=3.
- **Startup:** first `enable_fetch`=`enable_updatePC`=1 occurs RESET_STALL cycles after `rst` falls.
- **Enable ramp:** decode, execute and writeback enables follow 1, 2 and 3 cycles later.
- **Control flow:** fetch at cycle F of BR/JMP, resolve at F+3, next fetch at F+4. This is a 3-bubble penalty.
- **Memory:** an LD with `complete_data` arriving k cycles after entry stalls for k+1 cycles. LDI/STI add a second phase.
- **Output paths:** `br_taken` and `enable_*` are combinational from registered state plus `Imem_dout`/`IR_Exec`/`NZP`/`complete_data`. There is no combinational path from `rst`.

## Structure
- **Package `lc3_pkg`:**
  - opcode localparams;
  - `mem_state_t` enum (RD=0, RD_IND=1, WR=2, IDLE=3);
  - helper functions `is_load`, `is_store`, `is_ctrl`.
- **Sub-module `lc3_mem_fsm`:** owns the memory FSM and produces `mem_state`, `mem_stall` and `ld_done`. The top level holds the valid chain, control counter and enable logic.

## Test plan
1. **Reset release:** with RESET_STALL=1, fetch asserts on cycle 1. Decode, execute and writeback then ramp on cycles 2, 3 and 4. `mem_state`=3 throughout.
2. **BR taken:** BR nzp=010 (0x0402) with `NZP`=010. Fetch is low for 3 cycles and `br_taken`=1 at F+3. With `NZP`=100, `br_taken`=0.
3. **JMP (0xC1C0):** `br_taken`=1 at F+3 regardless of `NZP`. Fetch resumes at F+4.
4. **LDI with `complete_data` delayed 2 cycles per phase:** `mem_state` sequence is 1,1,1,0,0,0,3. `enable_writeback` pulses once on the final RD cycle.
5. **STI:** `mem_state` sequence is 1 then 2, and `enable_writeback` is never asserted. **STR:** `mem_state`=2 only.
6. **`rst` asserted mid-RD_IND:** the next cycle shows `mem_state`=3 and all enables 0.
